serial_add16_ctrl: RTL and testbench
====================================

SERIAL_ADD16_CTRL -- requirements
Module: serial_add16_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  request a new operation; sampled on rising clk.
REQ-006 sub  in  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-007 a  in  W  operand A; sampled with start.
REQ-008 b  in  W  operand B; sampled with start.
REQ-009 cin  in  1  carry-in for add; ignored when sub=1.
REQ-010 busy  out  1  high while an operation is in progress.
REQ-011 done  out  1  single-cycle pulse marking valid result.
REQ-012 sum  out  W  result; held between operations.
REQ-013 cout  out  1  carry-out of MSB slice; for sub, 1 = no borrow.
REQ-014 ovf  out  1  two's-complement signed overflow of the result.

Function
REQ-015 The block SHALL compute the W-bit result one 4-bit slice per clock, LSB slice first, through a single instance of the team's 4-bit ripple adder (fa4).
REQ-016 The FSM SHALL have states IDLE, RUN, DONE; IDLE is entered at reset.
REQ-017 In IDLE or DONE, start=1 SHALL latch a; latch b (b inverted when sub=1); set carry register to (sub ? 1 : cin); clear slice index; go to RUN.
REQ-018 In RUN, each cycle SHALL add slice[idx] of the latched operands plus the carry register, store the 4-bit sum into slice idx of an internal result register, update the carry register with fa4 Cout, and increment idx.
REQ-019 When idx = NIBBLES-1 in RUN, the next state SHALL be DONE; on that edge sum SHALL load the full internal result, cout the final carry, ovf = (carry into MSB bit) XOR (carry out of MSB bit).
REQ-020 In DONE, done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE unless start=1 (REQ-017).
REQ-021 busy SHALL be 1 exactly when state = RUN.
REQ-022 Latency: with start sampled on edge E0, done SHALL be high in the cycle after edge E(NIBBLES); for NIBBLES=4, 5 cycles from start edge to done.
REQ-023 start while busy=1 SHALL be ignored; operands and mode SHALL NOT change mid-operation.
REQ-024 sum, cout, ovf SHALL change only on the completion edge (REQ-019) and on reset; they SHALL hold their values otherwise, including during RUN.
REQ-025 Arithmetic wraps modulo 2^W; no saturation.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, idx=0, carry=0, internal result=0, sum=0, cout=0, ovf=0, busy=0, done=0.
REQ-027 Reset asserted during RUN SHALL abort the operation with no done pulse; sum SHALL read 0 afterward.
REQ-028 Deassertion of rst_n SHALL be synchronized to clk before it reaches the FSM; the first start is accepted on the second rising edge after deassertion.

Verification
REQ-029 a=0x1234, b=0x4321, sub=0, cin=0 -> after 5 cycles done=1, sum=0x5555, cout=0, ovf=0; busy high for 4 cycles.
REQ-030 a=0xFFFF, b=0x0001, sub=0, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-031 a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-032 start with a=0x1111, b=0x1111; pulse start with a=0xFFFF on cycles 2 and 3 -> single done, sum=0x2222.
REQ-033 start 0x00FF+0x0001; assert rst_n=0 in cycle 3 -> sum=0, no done pulse; after release, 0x0001+0x0001 -> sum=0x0002.
REQ-034 start held high continuously -> back-to-back operations, each done pulse 5 cycles apart, with sum updated only on each completion edge.

Source files
------------

// File: rtl/serial_add16_ctrl.sv
// serial_add16_ctrl: nibble-serial add/subtract through one 4-bit ripple adder, 3-state FSM

// fa4: 4-bit ripple-carry adder, also exposing the carry into bit 3 for overflow detection
module fa4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o,
  output logic       c3_o
);
  logic [4:0] c;
  assign c[0] = ci_i;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign co_o = c[4];
  assign c3_o = c[3];
endmodule

module serial_add16_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic          sync_q;
  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic          c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [3:0]    fs;
  logic          fco, fc3;
  logic [W-1:0]  res_n;
  logic          go, last;

  fa4 u_fa4 (
    .a_i (a_q[4*idx_q +: 4]),
    .b_i (b_q[4*idx_q +: 4]),
    .ci_i(c_q),
    .s_o (fs),
    .co_o(fco),
    .c3_o(fc3)
  );

  assign go   = start && (state_q != RUN);
  assign last = idx_q == IW'(NIBBLES - 1);
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

  // reset release is retimed to clk so the FSM leaves reset one edge after deassertion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= 1'b0;
    else        sync_q <= 1'b1;

  // next-state: accept a new operation, step one slice per cycle, publish on the last slice
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    res_n   = res_q;
    res_n[4*idx_q +: 4] = fs;
    if (go) begin
      state_d = RUN;
      idx_d   = '0;
      a_d     = a;
      b_d     = sub ? ~b : b;
      c_d     = sub | cin;
    end else if (state_q == RUN) begin
      res_d   = res_n;
      c_d     = fco;
      idx_d   = idx_q + IW'(1);
      state_d = last ? DONE : RUN;
      sum_d   = last ? res_n : sum_q;
      cout_d  = last ? fco : cout_q;
      ovf_d   = last ? (fc3 ^ fco) : ovf_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    if (!sync_q) begin
      state_d = IDLE;
      idx_d   = '0;
      a_d     = '0;
      b_d     = '0;
      c_d     = 1'b0;
      res_d   = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  // state registers, cleared immediately by rst_n
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
endmodule

// File: tb/tb_serial_add16_ctrl.sv
// tb_serial_add16_ctrl: directed vectors with a scoreboard queue checked by a done-driven monitor
module tb_serial_add16_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start, sub, cin;
  logic [15:0] a, b, sum;
  logic        busy, done, cout, ovf;
  logic [17:0] sb_q[$];
  logic [15:0] prev_sum = 16'h0000;
  int          checks = 0;
  int          errors = 0;

  serial_add16_ctrl #(.NIBBLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual_sum=%h expected=no_done", sum);
      end else begin
        e = sb_q.pop_front();
        chk("sum", 32'(sum), 32'(e[17:2]));
        chk("cout", 32'(cout), 32'(e[1]));
        chk("ovf", 32'(ovf), 32'(e[0]));
        prev_sum = e[17:2];
      end
    end
  end

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts, input logic tc,
                        input logic [15:0] es, input logic ec, input logic eo);
    int n, nb;
    @(negedge clk);
    a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
    sb_q.push_back({es, ec, eo});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; sub = ~ts;
    n = 1; nb = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      chk("sum_hold", 32'(sum), 32'(prev_sum));
      @(negedge clk);
      n++;
    end
    chk("latency", n, 5);
    chk("busy_cycles", nb, 4);
  endtask

  initial begin
    int k, nd;
    int dpos[3];
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout_ovf", 32'({cout, ovf}), 0);
    // start presented as reset releases: first accepted on the second edge
    rst_n = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0002;
    sb_q.push_back({16'h0003, 1'b0, 1'b0});
    @(negedge clk);
    chk("sync_edge1_busy", 32'(busy), 0);
    @(negedge clk);
    chk("sync_edge2_busy", 32'(busy), 1);
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin @(negedge clk); k++; end
    chk("first_done_seen", 32'(done), 1);
    run_op(16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0);
    run_op(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    run_op(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    run_op(16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0);
    run_op(16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1);
    run_op(16'h0005, 16'h0007, 1, 0, 16'hFFFE, 0, 0);
    run_op(16'h00FF, 16'h0000, 0, 1, 16'h0100, 0, 0);
    run_op(16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1);
    run_op(16'hABCD, 16'h1111, 0, 0, 16'hBCDE, 0, 0);
    // start pulsed mid-operation is ignored
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
    sb_q.push_back({16'h2222, 1'b0, 1'b0});
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    @(negedge clk); start = 1'b0; a = 16'h0000;
    k = 0;
    while (!done && k < 20) begin @(negedge clk); k++; end
    chk("ignore_done_seen", 32'(done), 1);
    repeat (10) @(negedge clk);
    // reset mid-operation aborts with no done
    a = 16'h00FF; b = 16'h0001; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_sum", 32'(sum), 0);
    chk("abort_busy_done", 32'({busy, done}), 0);
    prev_sum = 16'h0000;
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done_sum", 32'(sum), 0);
    run_op(16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0);
    // start held high: back-to-back operations
    @(negedge clk);
    a = 16'h0100; b = 16'h0200; sub = 1'b0; cin = 1'b0; start = 1'b1;
    sb_q.push_back({16'h0300, 1'b0, 1'b0});
    sb_q.push_back({16'h3000, 1'b0, 1'b0});
    sb_q.push_back({16'h3000, 1'b0, 1'b0});
    @(negedge clk);
    a = 16'h1000; b = 16'h2000;
    nd = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 11) start = 1'b0;
      if (done) begin
        if (nd < 3) dpos[nd] = i;
        nd++;
      end else chk("b2b_hold", 32'(sum), 32'(prev_sum));
      @(negedge clk);
    end
    chk("b2b_count", nd, 3);
    if (nd >= 3) begin
      chk("b2b_gap1", dpos[1] - dpos[0], 5);
      chk("b2b_gap2", dpos[2] - dpos[1], 5);
    end
    repeat (6) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
